// File: rtl/x_uart_tx_fifo_if.sv
// Push-side and transmitter-side signals of the UART TX byte buffer.
// The slave modport is the FIFO; the master modport is the producer/transmitter pair.
interface x_uart_tx_fifo_if #(
  parameter int p_depth = 16,
  parameter int p_width = 8
);
  localparam int c_lw = $clog2(p_depth) + 1;

  logic [p_width-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic               i_flush;
  logic [p_width-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_accept;
  logic [c_lw-1:0]    o_level;
  logic               o_overflow;

  modport slave (
    input  i_data, i_valid, i_flush, i_tx_accept,
    output o_ready, o_tx_data, o_tx_valid, o_level, o_overflow
  );

  modport master (
    output i_data, i_valid, i_flush, i_tx_accept,
    input  o_ready, o_tx_data, o_tx_valid, o_level, o_overflow
  );
endinterface

// File: rtl/x_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; the head byte stays stable on o_tx_data
// until the transmitter accepts it at the end of the stop bit.
module x_uart_tx_fifo #(
  parameter int p_depth = 16,
  parameter int p_width = 8
) (
  input logic             i_clk,
  input logic             i_rst_n,
  x_uart_tx_fifo_if.slave bus
);
  localparam int c_aw = $clog2(p_depth);
  localparam int c_pw = c_aw + 1;

  logic [c_pw-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [c_pw-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [c_pw-1:0]    level_reg, level_next;
  logic               overflow_reg, overflow_next;
  logic [p_width-1:0] mem_reg [p_depth];

  logic empty, full, ready, push_en, pop_en;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {c_aw{1'b0}}});
  assign ready   = !full && !bus.i_flush;
  assign push_en = bus.i_valid && ready;
  assign pop_en  = bus.i_tx_accept && !empty;

  // A flush on a non-empty FIFO keeps only the head byte (it is mid-frame);
  // if that head is accepted in the same cycle the FIFO ends up empty.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    if (bus.i_flush) begin
      overflow_next = 1'b0;
      if (!empty) begin
        wr_ptr_next = rd_ptr_reg + c_pw'(1);
        if (pop_en)
          rd_ptr_next = rd_ptr_reg + c_pw'(1);
      end
    end else begin
      if (push_en)
        wr_ptr_next = wr_ptr_reg + c_pw'(1);
      if (pop_en)
        rd_ptr_next = rd_ptr_reg + c_pw'(1);
      if (bus.i_valid && full)
        overflow_next = 1'b1;
    end
    level_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // Never written at the read index while valid, since a push into the head slot needs full.
  generate
    for (genvar gi = 0; gi < p_depth; gi++) begin : g_entry
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          mem_reg[gi] <= '0;
        else if (push_en && (wr_ptr_reg[c_aw-1:0] == c_aw'(gi)))
          mem_reg[gi] <= bus.i_data;
      end
    end
  endgenerate

  assign bus.o_ready    = ready;
  assign bus.o_tx_valid = !empty;
  assign bus.o_tx_data  = mem_reg[rd_ptr_reg[c_aw-1:0]];
  assign bus.o_level    = level_reg;
  assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_x_uart_tx_fifo.sv
// Directed bench for x_uart_tx_fifo: reset, framing hold, fill/overflow, wrap,
// simultaneous push/pop, flush and mid-operation reset.
module tb_x_uart_tx_fifo;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  x_uart_tx_fifo_if #(.p_depth(16), .p_width(8)) bus ();

  x_uart_tx_fifo #(.p_depth(16), .p_width(8)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = base + 8'(k);
      step();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, {31'd0, bus.o_tx_valid}, 32'd1);
    check(tag, {24'd0, bus.o_tx_data}, {24'd0, exp});
    bus.i_tx_accept = 1'b1;
    step();
    bus.i_tx_accept = 1'b0;
  endtask

  initial begin
    logic [7:0] wbyte;
    bus.i_data      = 8'h00;
    bus.i_valid     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_tx_accept = 1'b0;

    // Reset then idle
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
    check("rst_ready",    {31'd0, bus.o_ready},    32'd1);
    check("rst_txvalid",  {31'd0, bus.o_tx_valid}, 32'd0);
    check("rst_level",    {27'd0, bus.o_level},    32'd0);
    check("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
    check("rst_txdata",   {24'd0, bus.o_tx_data},  32'h00);
    $display("reset/idle done");

    // Single byte; no same-cycle bypass
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h55;
    #1;
    check("no_bypass", {31'd0, bus.o_tx_valid}, 32'd0);
    step();
    bus.i_valid = 1'b0;
    check("single_level", {27'd0, bus.o_level}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("frame_hold_valid", {31'd0, bus.o_tx_valid}, 32'd1);
      check("frame_hold_data",  {24'd0, bus.o_tx_data},  32'h55);
      step();
    end
    pop_expect("single_pop", 8'h55);
    check("single_empty_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    check("single_empty_level", {27'd0, bus.o_level},    32'd0);
    bus.i_tx_accept = 1'b1;
    step();
    bus.i_tx_accept = 1'b0;
    check("accept_empty_level", {27'd0, bus.o_level}, 32'd0);
    check("accept_empty_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    $display("single byte done");

    // Fill and overflow
    push_seq(8'h00, 16);
    check("full_level", {27'd0, bus.o_level}, 32'd16);
    check("full_ready", {31'd0, bus.o_ready}, 32'd0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hAA;
    step();
    bus.i_valid = 1'b0;
    check("ovf_set",   {31'd0, bus.o_overflow}, 32'd1);
    check("ovf_level", {27'd0, bus.o_level},    32'd16);
    for (int i = 0; i < 16; i++) pop_expect("fill_drain", 8'(i));
    check("fill_drained", {31'd0, bus.o_tx_valid}, 32'd0);
    check("ovf_sticky",   {31'd0, bus.o_overflow}, 32'd1);
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    check("flush_empty_ovf",   {31'd0, bus.o_overflow}, 32'd0);
    check("flush_empty_level", {27'd0, bus.o_level},    32'd0);
    $display("fill/overflow done");

    // Wrap-around: 3 x (push 10 / drain 10)
    wbyte = 8'h80;
    for (int r = 0; r < 3; r++) begin
      push_seq(wbyte, 10);
      check("wrap_level", {27'd0, bus.o_level}, 32'd10);
      for (int i = 0; i < 10; i++) pop_expect("wrap_drain", wbyte + 8'(i));
      check("wrap_empty", {31'd0, bus.o_tx_valid}, 32'd0);
      wbyte = wbyte + 8'd10;
    end
    $display("wrap done");

    // Simultaneous push/pop, not full
    push_seq(8'h10, 5);
    check("sim_level_pre", {27'd0, bus.o_level}, 32'd5);
    bus.i_valid     = 1'b1;
    bus.i_data      = 8'h3C;
    bus.i_tx_accept = 1'b1;
    step();
    bus.i_valid     = 1'b0;
    bus.i_tx_accept = 1'b0;
    check("sim_level_post", {27'd0, bus.o_level}, 32'd5);
    for (int i = 1; i < 5; i++) pop_expect("sim_drain", 8'h10 + 8'(i));
    pop_expect("sim_drain_last", 8'h3C);
    check("sim_empty", {27'd0, bus.o_level}, 32'd0);

    // Simultaneous push/pop while full: push refused
    push_seq(8'h20, 16);
    bus.i_valid     = 1'b1;
    bus.i_data      = 8'h77;
    bus.i_tx_accept = 1'b1;
    #1;
    check("simfull_ready", {31'd0, bus.o_ready}, 32'd0);
    step();
    bus.i_valid     = 1'b0;
    bus.i_tx_accept = 1'b0;
    check("simfull_level", {27'd0, bus.o_level},    32'd15);
    check("simfull_ovf",   {31'd0, bus.o_overflow}, 32'd1);
    for (int i = 1; i < 16; i++) pop_expect("simfull_drain", 8'h20 + 8'(i));
    check("simfull_empty", {31'd0, bus.o_tx_valid}, 32'd0);
    $display("simultaneous push/pop done");

    // Flush mid-frame (overflow still set from above)
    push_seq(8'h41, 6);
    check("flush_pre_level", {27'd0, bus.o_level},    32'd6);
    check("flush_pre_ovf",   {31'd0, bus.o_overflow}, 32'd1);
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h99;
    #1;
    check("flush_ready", {31'd0, bus.o_ready}, 32'd0);
    step();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    check("flush_level", {27'd0, bus.o_level},    32'd1);
    check("flush_head",  {24'd0, bus.o_tx_data},  32'h41);
    check("flush_ovf",   {31'd0, bus.o_overflow}, 32'd0);
    pop_expect("flush_pop", 8'h41);
    check("flush_after_empty", {31'd0, bus.o_tx_valid}, 32'd0);

    // Flush coincident with accept
    push_seq(8'h50, 3);
    bus.i_flush     = 1'b1;
    bus.i_tx_accept = 1'b1;
    step();
    bus.i_flush     = 1'b0;
    bus.i_tx_accept = 1'b0;
    check("flushacc_level", {27'd0, bus.o_level},    32'd0);
    check("flushacc_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    push_seq(8'h60, 1);
    check("flushacc_next_level", {27'd0, bus.o_level},   32'd1);
    check("flushacc_next_data",  {24'd0, bus.o_tx_data}, 32'h60);
    $display("flush done");

    // Asynchronous reset mid-operation
    push_seq(8'h70, 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    check("arst_level", {27'd0, bus.o_level},    32'd0);
    check("arst_data",  {24'd0, bus.o_tx_data},  32'h00);
    check("arst_ready", {31'd0, bus.o_ready},    32'd1);
    step();
    i_rst_n = 1'b1;
    step();
    check("arst_release_level", {27'd0, bus.o_level}, 32'd0);
    $display("async reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
